// File: rtl/tff_toggle_decoder_pkg.sv
// Shared types and defaults for the toggle-line decoder.
package tff_toggle_decoder_pkg;

    typedef enum logic {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int CNT_W_DEF = 8;
    localparam int TOG_W_DEF = 16;

    // Saturating increment for the run counter.
    function automatic logic [CNT_W_DEF-1:0] sat_inc_def(input logic [CNT_W_DEF-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/tff_toggle_decoder_if.sv
// Run-length delivery channel: one value per handshake.
interface tff_toggle_decoder_if #(
    parameter int CNT_W = 8
);
    logic [CNT_W-1:0] run_len;
    logic             run_valid;
    logic             run_ready;

    modport master (output run_len, output run_valid, input  run_ready);
    modport slave  (input  run_len, input  run_valid, output run_ready);
endinterface

// File: rtl/tff_edge_detect.sv
// Registers the toggle line and turns each change into a one-cycle pulse.
module tff_edge_detect (
    input  logic CLK,
    input  logic RST,
    input  logic q_in,
    input  logic en,
    output logic q_reg,
    output logic tog,
    output logic t_out
);
    logic q_reg_q, q_reg_d;
    logic t_out_q, t_out_d;

    // q_reg tracks the line even while disabled so re-enable is glitch-free.
    assign tog = en & (q_in ^ q_reg_q);

    // Next-state for the line copy and pulse output.
    always_comb begin
        q_reg_d = q_in;
        t_out_d = tog;
    end

    // Line copy and pulse registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            q_reg_q <= 1'b0;
            t_out_q <= 1'b0;
        end else begin
            q_reg_q <= q_reg_d;
            t_out_q <= t_out_d;
        end
    end

    assign q_reg = q_reg_q;
    assign t_out = t_out_q;
endmodule

// File: rtl/tff_toggle_decoder.sv
// Toggle-line decoder: pulse recovery, toggle count and run-length reporting.
// state   | meaning
// SYNC    | start of current run unknown; first toggle only arms the counter
// RUN     | counting cycles since the last toggle; next toggle reports a run
module tff_toggle_decoder
    import tff_toggle_decoder_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int TOG_W = TOG_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              q_in,
    input  logic              en,
    output logic              t_out,
    output logic              q_reg,
    output logic [TOG_W-1:0]  tog_count,
    output logic              sat,
    output logic              overflow,
    tff_toggle_decoder_if.master run_if
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic tog;

    tff_edge_detect u_edge (
        .CLK   (CLK),
        .RST   (RST),
        .q_in  (q_in),
        .en    (en),
        .q_reg (q_reg),
        .tog   (tog),
        .t_out (t_out)
    );

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   run_len_q, run_len_d;
    logic               run_valid_q, run_valid_d;
    logic [TOG_W-1:0]   tog_count_q, tog_count_d;
    logic               sat_q, sat_d;
    logic               overflow_q, overflow_d;
    logic               report;
    logic               consume;

    // Run FSM, counters and single-entry output slot.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        run_len_d   = run_len_q;
        run_valid_d = run_valid_q;
        tog_count_d = tog_count_q + {{(TOG_W-1){1'b0}}, tog};
        sat_d       = sat_q;
        overflow_d  = overflow_q;
        report      = 1'b0;
        consume     = run_valid_q & run_if.run_ready;

        if (!en) begin
            state_d = ST_SYNC;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_SYNC: begin
                    if (tog) begin
                        state_d = ST_RUN;
                        cnt_d   = CNT_ONE;
                    end
                end
                ST_RUN: begin
                    if (tog) begin
                        report = 1'b1;
                        cnt_d  = CNT_ONE;
                    end else begin
                        cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
                        if (cnt_d == CNT_MAX) sat_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_SYNC;
                    cnt_d   = '0;
                end
            endcase
        end

        // A full slot that is not drained this edge drops the new run.
        if (report && (!run_valid_q || consume)) begin
            run_len_d   = cnt_q;
            run_valid_d = 1'b1;
        end else if (report) begin
            overflow_d  = 1'b1;
        end else if (consume) begin
            run_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_SYNC;
            cnt_q       <= '0;
            run_len_q   <= '0;
            run_valid_q <= 1'b0;
            tog_count_q <= '0;
            sat_q       <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            run_len_q   <= run_len_d;
            run_valid_q <= run_valid_d;
            tog_count_q <= tog_count_d;
            sat_q       <= sat_d;
            overflow_q  <= overflow_d;
        end
    end

    assign run_if.run_len   = run_len_q;
    assign run_if.run_valid = run_valid_q;
    assign tog_count        = tog_count_q;
    assign sat              = sat_q;
    assign overflow         = overflow_q;
endmodule

// File: tb/tb_tff_toggle_decoder.sv
// Bench for tff_toggle_decoder: directed scenarios plus random traffic vs. a cycle-index model.
module tb_tff_toggle_decoder;
    localparam int TB_CNT_W = 4;
    localparam int TB_TOG_W = 6;
    localparam int MAXC     = (1 << TB_CNT_W) - 1;

    logic CLK = 1'b0;
    logic RST, q_in, en;
    logic t_out, q_reg, sat, overflow;
    logic [TB_TOG_W-1:0] tog_count;

    tff_toggle_decoder_if #(.CNT_W(TB_CNT_W)) rif ();

    tff_toggle_decoder #(.CNT_W(TB_CNT_W), .TOG_W(TB_TOG_W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .q_in      (q_in),
        .en        (en),
        .t_out     (t_out),
        .q_reg     (q_reg),
        .tog_count (tog_count),
        .sat       (sat),
        .overflow  (overflow),
        .run_if    (rif)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: remembers the edge index of the last toggle of the current run.
    int                  m_edge = 0;
    int                  m_last = -1;
    logic                m_qreg = 1'b0;
    logic                m_tout = 1'b0;
    logic                m_valid = 1'b0;
    logic [TB_CNT_W-1:0] m_len = '0;
    logic [TB_TOG_W-1:0] m_tog = '0;
    logic                m_sat = 1'b0;
    logic                m_ovf = 1'b0;

    task automatic step(input logic r, input logic q, input logic e, input logic rd);
        int  gap;
        logic t, cons, rep;
        logic [TB_CNT_W-1:0] val;
        @(negedge CLK);
        RST = r; q_in = q; en = e; rif.run_ready = rd;
        @(posedge CLK);
        if (r) begin
            m_qreg = 0; m_tout = 0; m_valid = 0; m_len = '0; m_tog = '0;
            m_sat = 0; m_ovf = 0; m_last = -1;
        end else begin
            t    = e && (q != m_qreg);
            cons = m_valid && rd;
            rep  = 1'b0;
            val  = '0;
            if (!e) m_last = -1;
            else if (t) begin
                if (m_last >= 0) begin
                    gap = m_edge - m_last;
                    rep = 1'b1;
                    val = TB_CNT_W'((gap > MAXC) ? MAXC : gap);
                end
                m_last = m_edge;
            end else if (m_last >= 0 && (m_edge - m_last + 1) >= MAXC) begin
                m_sat = 1'b1;
            end
            if (rep && (!m_valid || cons)) begin m_len = val; m_valid = 1'b1; end
            else if (rep) m_ovf = 1'b1;
            else if (cons) m_valid = 1'b0;
            m_tout = t;
            m_tog  = m_tog + TB_TOG_W'(t);
            m_qreg = q;
        end
        m_edge++;
        #1;
    endtask

    task automatic test_reset();
        step(1, 1, 1, 1);
        step(1, 1, 1, 1);
        n_cmp++; if ({t_out, q_reg, rif.run_valid, sat, overflow} !== 5'b0) begin
            n_bad++; $display("FAIL reset_flags got=%b exp=00000", {t_out, q_reg, rif.run_valid, sat, overflow}); end
        n_cmp++; if (rif.run_len !== '0 || tog_count !== '0) begin
            n_bad++; $display("FAIL reset_counts got len=%0d tog=%0d exp 0/0", rif.run_len, tog_count); end
        step(0, 1, 1, 1);
        n_cmp++; if (t_out !== 1'b1 || tog_count !== TB_TOG_W'(1) || rif.run_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_first_toggle got t=%b tog=%0d v=%b exp 1/1/0", t_out, tog_count, rif.run_valid); end
        step(0, 1, 1, 1);
        n_cmp++; if (t_out !== 1'b0 || q_reg !== 1'b1) begin
            n_bad++; $display("FAIL reset_pulse_width got t=%b q=%b exp 0/1", t_out, q_reg); end
    endtask

    task automatic test_periodic();
        int pulses = 0, reports = 0;
        step(1, 0, 1, 1);
        for (int i = 0; i < 10; i++) begin
            step(0, ((i / 2) % 2) == 0, 1, 1);
            if (t_out) pulses++;
            if (rif.run_valid && rif.run_len == TB_CNT_W'(2)) reports++;
        end
        n_cmp++; if (pulses != 5 || tog_count !== TB_TOG_W'(5)) begin
            n_bad++; $display("FAIL periodic_toggles got pulses=%0d tog=%0d exp 5/5", pulses, tog_count); end
        n_cmp++; if (reports != 4 || overflow !== 1'b0) begin
            n_bad++; $display("FAIL periodic_runs got reports=%0d ovf=%b exp 4/0", reports, overflow); end
    endtask

    task automatic test_backpressure();
        logic q = 1'b0;
        step(1, 0, 1, 0);
        for (int e = 0; e < 8; e++) begin
            if (e == 0 || e == 3 || e == 7) q = ~q;
            step(0, q, 1, 0);
            if (e == 3) begin
                n_cmp++; if (rif.run_valid !== 1'b1 || rif.run_len !== TB_CNT_W'(3)) begin
                    n_bad++; $display("FAIL bp_first got v=%b len=%0d exp 1/3", rif.run_valid, rif.run_len); end
            end
        end
        n_cmp++; if (rif.run_len !== TB_CNT_W'(3) || rif.run_valid !== 1'b1 || overflow !== 1'b1) begin
            n_bad++; $display("FAIL bp_drop got len=%0d v=%b ovf=%b exp 3/1/1", rif.run_len, rif.run_valid, overflow); end
        step(0, q, 1, 1);
        n_cmp++; if (rif.run_valid !== 1'b0) begin
            n_bad++; $display("FAIL bp_drain got v=%b exp 0", rif.run_valid); end
    endtask

    task automatic test_saturation();
        step(1, 0, 1, 1);
        step(0, 1, 1, 1);
        for (int i = 0; i < 20; i++) step(0, 1, 1, 1);
        step(0, 0, 1, 1);
        n_cmp++; if (rif.run_len !== TB_CNT_W'(15) || rif.run_valid !== 1'b1 || sat !== 1'b1) begin
            n_bad++; $display("FAIL sat_run got len=%0d v=%b sat=%b exp 15/1/1", rif.run_len, rif.run_valid, sat); end
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        step(0, 1, 1, 1);
        n_cmp++; if (rif.run_len !== TB_CNT_W'(3) || sat !== 1'b1) begin
            n_bad++; $display("FAIL sat_sticky got len=%0d sat=%b exp 3/1", rif.run_len, sat); end
    endtask

    task automatic test_enable_gate();
        logic qs [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        step(1, 0, 1, 1);
        step(0, 1, 1, 1);
        step(0, 1, 1, 1);
        for (int i = 0; i < 5; i++) begin
            step(0, qs[i], 0, 1);
            n_cmp++; if (t_out !== 1'b0 || tog_count !== TB_TOG_W'(1)) begin
                n_bad++; $display("FAIL en_gate got t=%b tog=%0d exp 0/1", t_out, tog_count); end
        end
        step(0, 0, 1, 1);
        n_cmp++; if (t_out !== 1'b0) begin
            n_bad++; $display("FAIL en_no_spurious got t=%b exp 0", t_out); end
        step(0, 1, 1, 1);
        n_cmp++; if (t_out !== 1'b1 || tog_count !== TB_TOG_W'(2) || rif.run_valid !== 1'b0) begin
            n_bad++; $display("FAIL en_first_after got t=%b tog=%0d v=%b exp 1/2/0", t_out, tog_count, rif.run_valid); end
        for (int i = 0; i < 3; i++) step(0, 1, 1, 1);
        step(0, 0, 1, 1);
        n_cmp++; if (rif.run_valid !== 1'b1 || rif.run_len !== TB_CNT_W'(4)) begin
            n_bad++; $display("FAIL en_second_after got v=%b len=%0d exp 1/4", rif.run_valid, rif.run_len); end
    endtask

    task automatic test_back_to_back();
        step(1, 0, 1, 1);
        step(0, 1, 1, 1);
        step(0, 1, 1, 1);
        step(0, 0, 1, 1);
        step(0, 1, 1, 1);
        n_cmp++; if (rif.run_len !== TB_CNT_W'(1) || rif.run_valid !== 1'b1 || overflow !== 1'b0) begin
            n_bad++; $display("FAIL b2b_load got len=%0d v=%b ovf=%b exp 1/1/0", rif.run_len, rif.run_valid, overflow); end
        step(1, 1, 1, 1);
        n_cmp++; if (rif.run_valid !== 1'b0 || tog_count !== '0) begin
            n_bad++; $display("FAIL b2b_reset got v=%b tog=%0d exp 0/0", rif.run_valid, tog_count); end
    endtask

    task automatic test_random();
        logic q = 1'b0;
        int   slow = 0;
        step(1, 0, 1, 1);
        for (int i = 0; i < 3000; i++) begin
            if (i % 120 == 0) slow = $urandom_range(0, 1);
            if (slow != 0 ? ($urandom_range(0, 24) == 0) : ($urandom_range(0, 1) == 0)) q = ~q;
            step($urandom_range(0, 299) == 0, q, $urandom_range(0, 15) != 0, $urandom_range(0, 3) == 0);
            n_cmp++; if ({t_out, q_reg, rif.run_valid, sat, overflow} !== {m_tout, m_qreg, m_valid, m_sat, m_ovf}) begin
                n_bad++; $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", i,
                    {t_out, q_reg, rif.run_valid, sat, overflow}, {m_tout, m_qreg, m_valid, m_sat, m_ovf}); end
            n_cmp++; if (rif.run_len !== m_len || tog_count !== m_tog) begin
                n_bad++; $display("FAIL rnd_counts cyc=%0d got len=%0d tog=%0d exp len=%0d tog=%0d", i,
                    rif.run_len, tog_count, m_len, m_tog); end
        end
    endtask

    initial begin
        RST = 1'b1; q_in = 1'b0; en = 1'b0; rif.run_ready = 1'b0;
        test_reset();
        test_periodic();
        test_backpressure();
        test_saturation();
        test_enable_gate();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/tff_toggle_decoder.md
Name: tff_toggle_decoder

Overview:
Receive-side decoder for a toggle-encoded line, such as the Q output of a T flip-flop driven by a t pulse stream. It recovers the original one-cycle t pulses and counts toggles. It also measures the run length, in clock cycles, between consecutive toggles and delivers each run length through a valid/ready handshake. It sits downstream of the T flip-flop blocks as their checker/consumer end.

Parameters:
CNT_W, 8, width of the run-length counter and of run_len
TOG_W, 16, width of the total-toggle counter

Ports:
CLK  in  1  rising-edge clock, the only clock
RST  in  1  reset, synchronous, active-high
q_in  in  1  toggle-encoded line, synchronous to CLK
en  in  1  decode enable
t_out  out  1  recovered toggle pulse
q_reg  out  1  registered copy of q_in
run_len  out  CNT_W  cycles between the last two toggles
run_valid  out  1  run_len holds an unconsumed value
run_ready  in  1  consumer accepts run_len
tog_count  out  TOG_W  toggles detected since reset, wraps modulo 2^TOG_W
sat  out  1  sticky; set when the run counter has saturated
overflow  out  1  sticky; set when a run was dropped because the output slot was full

Behaviour:
- Reset: when RST=1 at a CLK edge, every output goes to 0 and internal state is cleared:
  - t_out, q_reg, run_len, run_valid, tog_count, sat and overflow all become 0.
  - Run counter becomes 0 and the FSM goes to SYNC.
  - Reset mid-operation discards any pending run_len.
- q_reg <= q_in on every edge, independent of en.
- Toggle detect: tog = en & (q_in ^ q_reg).
  - t_out <= tog, giving 1 cycle of latency and a 1-cycle pulse per q_in change.
  - The first change relative to the post-reset q_reg=0 counts as a toggle.
- tog_count increments on every tog and wraps to 0 after its maximum value.
- FSM, two states:
  - SYNC: the start of the current run is unknown. On tog, go to RUN and set the run counter to 1. No run is reported.
  - RUN: on an edge without tog, the counter increments, saturating at 2^CNT_W-1; reaching saturation sets sat. On tog, report run = counter value, reload the counter to 1 and stay in RUN.
  - Run length therefore equals the number of CLK edges between two consecutive toggles. Example: toggles at edges 10 and 13 give run_len=3.
- en=0 at an edge:
  - No toggle is detected and t_out=0.
  - Run counter clears to 0 and the FSM goes to SYNC.
  - q_reg keeps tracking q_in, so re-enabling never produces a spurious toggle.
  - A pending run_len stays valid and can still be drained.
- Output slot, one entry:
  - The slot is free when run_valid=0, or when run_valid & run_ready are both high at this edge.
  - Report into a free slot: run_len <= value and run_valid <= 1.
  - Report into an occupied slot that is not consumed this edge: the new value is dropped, overflow is set, and run_len/run_valid are unchanged.
  - Consume with no report: run_valid <= 0.
  - Simultaneous consume and report: the new value loads and run_valid stays 1.
  - run_len is stable whenever run_valid=1 and no consume occurs.
- sat and overflow clear only on RST.

Decomposition:
- Shared package holds:
  - FSM state encoding: ST_SYNC=1'b0, ST_RUN=1'b1.
  - Default widths: CNT_W_DEF=8 and TOG_W_DEF=16.
- One sub-module is natural: tff_edge_detect.
  - Contains the q_reg register, the tog equation and the t_out register.
  - Shares CLK and RST with the top.
- Run counter, FSM and output slot stay in the top module.

Test Plan:
1. RST=1 for 2 cycles with q_in=1 -> all outputs 0. Release with en=1 -> t_out pulses once, tog_count=1, FSM in RUN, run_valid=0.
2. en=1, run_ready=1, q_in toggles every 2 edges for 5 toggles -> t_out pulses every 2 cycles and tog_count=5. run_valid asserts 4 times, each with run_len=2, and overflow=0.
3. run_ready=0, q_in toggles at edges 0, 3 and 7 -> run_len=3 held with run_valid=1. The second run (4) is dropped and overflow=1. Raising run_ready -> run_valid drops after 1 edge.
4. CNT_W=4, q_in held constant for 20 edges between toggles -> run_len=15 and sat=1. sat remains 1 after further normal runs.
5. en=0 for 5 cycles while q_in toggles 3 times -> t_out=0 and tog_count unchanged. After en=1, the first toggle reports no run; the second reports the correct gap.
6. run_valid=1 with run_ready=1 on the same edge as a new toggle report -> new run_len loaded, run_valid stays 1, overflow=0. RST asserted mid-run -> run_valid=0 and tog_count=0 on the next edge.
